// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = WORD_W / LANES;
    localparam int unsigned CNT_W  = 4;

    // Low address bits that must be zero for a word-aligned access
    localparam logic [WORD_W-1:0] ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic [LANES-1:0]  wstrb;
    } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage and the data-memory responder.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [LANES-1:0]  req_wstrb;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with per-byte write enables.
// Read data is registered and reads as zero in any cycle not following a read.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [LANES-1:0]  be,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

    // Byte-lane writes; storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (be[i]) begin
                    mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read data is zero unless a read is performed this cycle
    always_comb begin
        rdata_d = '0;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts MEM-stage loads/stores, waits WAIT_CYCLES,
// then answers with a single-beat response from internal SRAM.
// Optional feature macro: DMEM_BYTE_STRB_EN (honor req_wstrb per byte lane).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);

    localparam int unsigned       AW         = $clog2(DEPTH_WORDS);
    localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(DEPTH_WORDS * 4);
    localparam logic [CNT_W-1:0]  CNT_LOAD   = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             cap_q, cap_d;
    logic             req_ready_q, req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q, resp_err_d;

    req_t             live_c;
    req_t             acc_c;
    logic             hs_c;
    logic             acc_err_c;
    logic             ram_en_c;
    logic [LANES-1:0] ram_be_c;

    assign live_c = '{wr:    bus.req_wr,
                      addr:  bus.req_addr,
                      wdata: bus.req_wdata,
                      wstrb: bus.req_wstrb};

    assign hs_c = bus.req_valid & req_ready_q;

    // Access performed on the edge entering RESP: captured request after a wait, else the live one
    assign acc_c     = (state_q == ST_WAIT) ? cap_q : live_c;
    assign acc_err_c = ((acc_c.addr & ALIGN_MASK) != '0) || (acc_c.addr >= ADDR_LIMIT);

`ifdef DMEM_BYTE_STRB_EN
    assign ram_be_c = acc_c.wstrb;
`else
    logic unused_wstrb;
    assign unused_wstrb = ^acc_c.wstrb;
    assign ram_be_c     = {LANES{1'b1}};
`endif

    // Next-state, counter, capture and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cap_d        = cap_q;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (hs_c) begin
                    cap_d = live_c;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d  = (state_d != ST_WAIT);
        resp_valid_d = (state_d == ST_RESP);
        resp_err_d   = (state_d == ST_RESP) && acc_err_c;
        ram_en_c     = (state_d == ST_RESP) && !acc_err_c;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cap_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en_c),
        .we    (acc_c.wr),
        .be    (ram_be_c),
        .addr  (acc_c.addr[AW+1:2]),
        .wdata (acc_c.wdata),
        .rdata (bus.resp_rdata)
    );

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    // Drops in a RESP cycle with no follow-on request so the core releases its stall early
    assign bus.busy       = (state_q != ST_IDLE) && !((state_q == ST_RESP) && !hs_c);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: DUT 0 runs with no wait states, DUT 1 with two.
// A per-DUT scoreboard queues each accepted request with its due cycle and
// resolves the expected response against a reference memory when it is due.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          due;
    } txn_t;

    logic clk;
    logic rst;

    logic        vld [2];
    logic        wrs [2];
    logic [31:0] adr [2];
    logic [31:0] wdt [2];
    logic [3:0]  stb [2];
    logic        rdy [2];
    logic        rv  [2];
    logic        rerr[2];
    logic        bsy [2];
    logic [31:0] rdt [2];

    txn_t        sb  [2][$];
    logic [31:0] mdl [2][DEPTH];
    bit          hs_flag[2];
    int          hs_cyc [2];
    int          cyc;
    int          tests;
    int          fails;

    dmem_responder_if if_w0 ();
    dmem_responder_if if_w2 ();

    assign if_w0.req_valid = vld[0];
    assign if_w0.req_wr    = wrs[0];
    assign if_w0.req_addr  = adr[0];
    assign if_w0.req_wdata = wdt[0];
    assign if_w0.req_wstrb = stb[0];
    assign if_w2.req_valid = vld[1];
    assign if_w2.req_wr    = wrs[1];
    assign if_w2.req_addr  = adr[1];
    assign if_w2.req_wdata = wdt[1];
    assign if_w2.req_wstrb = stb[1];

    assign rdy[0]  = if_w0.req_ready;
    assign rv[0]   = if_w0.resp_valid;
    assign rerr[0] = if_w0.resp_err;
    assign bsy[0]  = if_w0.busy;
    assign rdt[0]  = if_w0.resp_rdata;
    assign rdy[1]  = if_w2.req_ready;
    assign rv[1]   = if_w2.resp_valid;
    assign rerr[1] = if_w2.resp_err;
    assign bsy[1]  = if_w2.busy;
    assign rdt[1]  = if_w2.resp_rdata;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if_w0.slave)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if_w2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference memory: resolves a transaction at its response time
    task automatic model(input int d, input txn_t t, output logic [31:0] rd, output logic er);
        logic [9:0] idx;
        idx = t.addr[11:2];
        er  = (t.addr[1:0] != 2'b00) || (t.addr >= 32'(DEPTH * 4));
        rd  = '0;
        if (!er) begin
            if (t.wr) begin
`ifdef DMEM_BYTE_STRB_EN
                for (int i = 0; i < 4; i++) begin
                    if (t.strb[i]) mdl[d][idx][8*i +: 8] = t.wdata[8*i +: 8];
                end
`else
                mdl[d][idx] = t.wdata;
`endif
            end else begin
                rd = mdl[d][idx];
            end
        end
    endtask

    task automatic check_dut(input int d);
        bit          pend, due_now, ready_e, busy_e, hs;
        txn_t        t;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       p;
        p       = $sformatf("d%0d c%0d ", d, cyc);
        pend    = sb[d].size() > 0;
        due_now = pend && (sb[d][0].due == cyc);
        ready_e = !(pend && !due_now);
        hs      = vld[d] && ready_e;
        busy_e  = pend && !(due_now && !hs);
        chk({p, "req_ready"},  32'(rdy[d]), 32'(ready_e));
        chk({p, "busy"},       32'(bsy[d]), 32'(busy_e));
        chk({p, "resp_valid"}, 32'(rv[d]),  32'(due_now));
        if (due_now) begin
            t = sb[d].pop_front();
            model(d, t, exp_rd, exp_err);
            chk({p, "resp_rdata"}, rdt[d],       exp_rd);
            chk({p, "resp_err"},   32'(rerr[d]), 32'(exp_err));
        end else begin
            chk({p, "idle_rdata"}, rdt[d],       32'h0);
            chk({p, "idle_err"},   32'(rerr[d]), 32'h0);
        end
        hs_flag[d] = hs;
        if (hs) begin
            t.wr    = wrs[d];
            t.addr  = adr[d];
            t.wdata = wdt[d];
            t.strb  = stb[d];
            t.due   = cyc + 1 + wait_of(d);
            sb[d].push_back(t);
            hs_cyc[d] = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; valid stays high on return
    task automatic req(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] dat, input logic [3:0] s);
        bit done;
        done   = 1'b0;
        vld[d] = 1'b1;
        wrs[d] = w;
        adr[d] = a;
        wdt[d] = dat;
        stb[d] = s;
        for (int n = 0; n < 50 && !done; n++) begin
            tick();
            if (hs_flag[d]) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $error("FAIL d%0d accept_timeout: got none want handshake for addr %h", d, a);
        end
    endtask

    task automatic drain(input int d);
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        for (int n = 0; n < 50 && sb[d].size() > 0; n++) tick();
        if (sb[d].size() > 0) begin
            tests++;
            fails++;
            $error("FAIL d%0d drain_timeout: got %0d pending want 0", d, sb[d].size());
        end
    endtask

    task automatic chk_reset_outputs(input int d, input string tag);
        chk({tag, " req_ready"},  32'(rdy[d]),  32'h1);
        chk({tag, " resp_valid"}, 32'(rv[d]),   32'h0);
        chk({tag, " resp_rdata"}, rdt[d],       32'h0);
        chk({tag, " resp_err"},   32'(rerr[d]), 32'h0);
        chk({tag, " busy"},       32'(bsy[d]),  32'h0);
    endtask

    initial begin
        int s_cyc;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vld[d] = 1'b0;
            wrs[d] = 1'b0;
            adr[d] = '0;
            wdt[d] = '0;
            stb[d] = '0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs(0, "reset0");
        chk_reset_outputs(1, "reset1");
        rst = 1'b1;
        tick();

        // Store then load, with idle between
        req(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        drain(1);
        req(1, 1'b0, 32'h10, 32'h0, 4'h0);
        drain(1);

        // Back-to-back store then load accepted in the store's RESP cycle
        req(1, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
        s_cyc = hs_cyc[1];
        req(1, 1'b0, 32'h20, 32'h0, 4'h0);
        chk("b2b_accept_cycle", 32'(hs_cyc[1]), 32'(s_cyc + 3));
        drain(1);

        // Errors: misaligned load, out-of-range store leaves word 0 untouched
        req(1, 1'b0, 32'h22, 32'h0, 4'h0);
        drain(1);
        req(1, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF);
        drain(1);
        req(1, 1'b1, 32'(DEPTH * 4), 32'h0BAD_0BAD, 4'hF);
        drain(1);
        req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        drain(1);
        req(1, 1'b1, 32'hFFC, 32'h7777_7777, 4'hF);
        req(1, 1'b0, 32'hFFC, 32'h0, 4'h0);
        drain(1);

        // Byte strobes
        req(1, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF);
        req(1, 1'b1, 32'h40, 32'h0000_00AB, 4'b0001);
        req(1, 1'b0, 32'h40, 32'h0, 4'h0);
        req(1, 1'b1, 32'h40, 32'h1234_5678, 4'b0000);
        req(1, 1'b0, 32'h40, 32'h0, 4'h0);
        req(1, 1'b1, 32'h44, 32'hA1B2_C3D4, 4'b1010);
        req(1, 1'b0, 32'h44, 32'h0, 4'h0);
        drain(1);

        // Reset in the middle of a store's wait states
        req(1, 1'b1, 32'h30, 32'h7, 4'hF);
        drain(1);
        req(1, 1'b1, 32'h30, 32'h5, 4'hF);
        vld[1] = 1'b0;
        tick();
        rst = 1'b0;
        sb[1].delete();
        #1;
        chk_reset_outputs(1, "midrst");
        tick();
        tick();
        rst = 1'b1;
        repeat (6) tick();
        req(1, 1'b0, 32'h30, 32'h0, 4'h0);
        drain(1);

        // No wait states: streaming loads from alternating addresses
        req(0, 1'b1, 32'h100, 32'hA5A5_A5A5, 4'hF);
        req(0, 1'b1, 32'h104, 32'h5A5A_5A5A, 4'hF);
        for (int i = 0; i < 10; i++) begin
            req(0, 1'b0, (i % 2 == 0) ? 32'h100 : 32'h104, 32'h0, 4'h0);
        end
        req(0, 1'b0, 32'h102, 32'h0, 4'h0);
        req(0, 1'b0, 32'h104, 32'h0, 4'h0);
        drain(0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
